// File: rtl/counter_async_reset.sv
// Binary up-counter wrapping modulo MAX_VALUE+1 with synchronous active-high reset.
// Define COUNTER_ASYNC_RESET_SATURATE_EN to saturate at MAX_VALUE instead of wrapping.
module counter_async_reset #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP      = 64'd1
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic [WIDTH-1:0] Count
);

  // Reject impossible configurations before anything is built.
  if ((WIDTH < 1) || (WIDTH > 32) || (MAX_VALUE >= (64'd1 << WIDTH)) ||
      (STEP == 64'd0) || (STEP > MAX_VALUE)) begin : g_bad_params
    $fatal(1, "counter_async_reset: illegal WIDTH/MAX_VALUE/STEP combination");
  end

  localparam logic [WIDTH:0] MAX_EXT  = MAX_VALUE[WIDTH:0];
  localparam logic [WIDTH:0] STEP_EXT = STEP[WIDTH:0];
  localparam logic [WIDTH:0] MODULUS  = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   wrap_s;
  logic [WIDTH-1:0] next_s;

  // Next-state: the extra sum bit keeps the terminal compare honest near 2**WIDTH.
  always_comb begin
    sum_s  = {1'b0, count_r} + STEP_EXT;
    wrap_s = sum_s - MODULUS;
    next_s = sum_s[WIDTH-1:0];
    if (sum_s > MAX_EXT) begin
`ifdef COUNTER_ASYNC_RESET_SATURATE_EN
      next_s = MAX_EXT[WIDTH-1:0];
`else
      next_s = wrap_s[WIDTH-1:0];
`endif
    end else begin
      next_s = sum_s[WIDTH-1:0];
    end
  end

  // Count register; reset wins over counting.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= next_s;
    end
  end

  assign Count = count_r;

endmodule

// File: tb/tb_counter_async_reset.sv
// Self-checking bench: a default counter and a MAX_VALUE=9/STEP=3 counter against an arithmetic model.
module tb_counter_async_reset;

  localparam int unsigned A_MAX  = 15;
  localparam int unsigned A_STEP = 1;
  localparam int unsigned B_MAX  = 9;
  localparam int unsigned B_STEP = 3;

  logic       clk;
  logic       rst;
  logic [3:0] count_a;
  logic [3:0] count_b;

  int unsigned checks;
  int unsigned passed;
  int unsigned exp_a;
  int unsigned exp_b;

  counter_async_reset dut_a (
    .Clock (clk),
    .Reset (rst),
    .Count (count_a)
  );

  counter_async_reset #(
    .WIDTH     (4),
    .MAX_VALUE (64'd9),
    .STEP      (64'd3)
  ) dut_b (
    .Clock (clk),
    .Reset (rst),
    .Count (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned model_next(input int unsigned cur, input int unsigned step,
                                             input int unsigned maxv);
`ifdef COUNTER_ASYNC_RESET_SATURATE_EN
    return (cur + step > maxv) ? maxv : cur + step;
`else
    return (cur + step) % (maxv + 1);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock edge with the given reset level, then compare both counters to the model.
  task automatic tick(input logic r);
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_a = 0;
      exp_b = 0;
    end else begin
      exp_a = model_next(exp_a, A_STEP, A_MAX);
      exp_b = model_next(exp_b, B_STEP, B_MAX);
    end
    check("count_a", {28'd0, count_a}, exp_a);
    check("count_b", {28'd0, count_b}, exp_b);
    @(negedge clk);
  endtask

  int unsigned wraps;
  logic [3:0]  prev_a;
  int unsigned seq_b [11];

  initial begin
    checks = 0;
    passed = 0;
    exp_a  = 0;
    exp_b  = 0;
    rst    = 1'b1;
    seq_b  = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
    @(negedge clk);

    // Single reset edge, then first counts.
    tick(1'b1);
    check("reset_a_zero", {28'd0, count_a}, 32'd0);
    tick(1'b0);
    check("first_a", {28'd0, count_a}, 32'd1);
    tick(1'b0);
    check("second_a", {28'd0, count_a}, 32'd2);

    // Run to 9 then reset mid-count.
    while (count_a != 4'd9 && checks < 200) tick(1'b0);
    check("reached_9", {28'd0, count_a}, 32'd9);
    tick(1'b1);
    check("mid_reset", {28'd0, count_a}, 32'd0);
    tick(1'b0);
    check("resume", {28'd0, count_a}, 32'd1);

    // Sixteen edges after reset: exactly one wrap (none when saturating).
    tick(1'b1);
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      prev_a = count_a;
      tick(1'b0);
      if (count_a < prev_a) wraps++;
    end
`ifdef COUNTER_ASYNC_RESET_SATURATE_EN
    check("wraps16", wraps, 32'd0);
    check("end16", {28'd0, count_a}, 32'd15);
`else
    check("wraps16", wraps, 32'd1);
    check("end16", {28'd0, count_a}, 32'd0);
`endif

    // Reset held for five edges.
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      check("held_reset", {28'd0, count_a}, 32'd0);
    end
    tick(1'b0);
    check("after_hold", {28'd0, count_a}, 32'd1);

    // Directed sequence for the MAX_VALUE=9, STEP=3 instance.
    tick(1'b1);
    for (int i = 1; i < 11; i++) begin
      tick(1'b0);
`ifdef COUNTER_ASYNC_RESET_SATURATE_EN
      check("seq_b_sat", {28'd0, count_b}, (i * 3 > 9) ? 32'd9 : i * 3);
`else
      check("seq_b", {28'd0, count_b}, seq_b[i]);
`endif
    end

    // Twenty edges after reset: saturating build pins at 15 from edge 15.
    tick(1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0);
`ifdef COUNTER_ASYNC_RESET_SATURATE_EN
      check("sat_a", {28'd0, count_a}, (i >= 15) ? 32'd15 : i);
`else
      check("wrap_a", {28'd0, count_a}, i % 16);
`endif
    end
    tick(1'b1);
    check("reset_after_run", {28'd0, count_a}, 32'd0);

    // Randomized reset pattern against the model.
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/counter_async_reset.md
Name: counter_async_reset

Overview:
- Free-running binary up-counter, default 4 bits, wrapping modulo a programmable terminal value.
- Used as a simple event/time-base counter clocked by the system clock.
- One clock domain. Synchronous active-high reset. Registered count output.
- The name is historical. The reset is synchronous, not asynchronous.

Parameters:
- WIDTH, 4, counter and output width in bits (1..32).
- MAX_VALUE, 2**WIDTH-1, terminal count. The counter wraps to 0 after this value. Must be <= 2**WIDTH-1.
- STEP, 1, increment applied per clock (1..MAX_VALUE).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
- Count  output  WIDTH  current counter value, driven directly from a register.

Interface (already decided):
- One clock (Clock).
- Reset is synchronous and active-high.
- Port order is Clock, Reset, Count.

Behaviour:
- Rising edge of Clock with Reset=1: Count <= 0. Reset has priority over counting.
- Rising edge of Clock with Reset=0:
  - If Count + STEP > MAX_VALUE: Count <= (Count + STEP) - (MAX_VALUE + 1). This is a modulo (MAX_VALUE+1) wrap.
  - Otherwise: Count <= Count + STEP.
- Compute the sum in WIDTH+1 bits so there is no silent overflow before the compare.
- Reset value of Count: 0.
- Count is undefined from power-up until the first rising edge with Reset=1. No initial block is relied on.
- Latency:
  - First count after reset deasserts: the first rising edge with Reset=0 yields STEP (1 by default).
  - Reset takes effect on the first rising edge at which it is sampled high.
- Reset held for N edges: Count stays 0 for all N edges.
- Reset mid-count: Count goes to 0 on that edge regardless of its current value, including at MAX_VALUE.
- Defaults (WIDTH=4, MAX_VALUE=15, STEP=1): sequence 0,1,...,15,0,1,... with period 16 clocks.
- No combinational path from any input to Count.
- Elaboration-time check: MAX_VALUE >= 2**WIDTH or STEP == 0 or STEP > MAX_VALUE is a fatal error.

Optional Feature:
- Macro: COUNTER_ASYNC_RESET_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - If Count + STEP > MAX_VALUE, then Count <= MAX_VALUE and holds there until Reset.
  - Reset still forces 0.
- Not defined: the wrap behaviour described in Behaviour applies.
- The macro affects only the next-state logic. Ports and parameters are identical in both builds.

Test Plan:
- Power-up, Reset=1 for one rising edge, then Reset=0 -> Count=0 after the reset edge, then 1 on the next edge, 2 on the one after.
- Reset low for 16 consecutive edges after reset (defaults) -> Count runs 1..15 then 0. Check wrap 15->0 exactly once per 16 edges.
- Reset asserted for one edge while Count=9 -> Count=0 on that edge, resumes 1 on the following edge.
- Reset held high for 5 edges -> Count stays 0 throughout; first increment on the edge after deassertion.
- Parameters MAX_VALUE=9, STEP=3, WIDTH=4 -> sequence 0,3,6,9,2,5,8,1,4,7,0 (wrap modulo 10).
- COUNTER_ASYNC_RESET_SATURATE_EN defined with defaults, 20 edges after reset -> Count reaches 15 at edge 15 and holds 15 through edge 20. Reset then returns it to 0.
